// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared definitions for the data-memory port arbiter: access length
// encodings and the sequencer state encoding.
package dm_arb_pkg;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_RSVD = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dm_lane_fmt.sv
// dm_lane_fmt
// Combinational lane handling for one latched access (little-endian lanes).
//   i_addr_lo  : byte offset of the access within the word
//   i_len      : access length (byte / half / word; reserved treated as word)
//   i_sign     : sign-extend a sub-word load
//   i_wdata    : right-aligned store data
//   i_mem_dout : word read from memory
//   o_merged   : i_mem_dout with the store lanes replaced by i_wdata
//   o_load     : extracted and extended load result
// Misaligned low bits are ignored here: a half uses only i_addr_lo[1], a word
// ignores i_addr_lo entirely.
module dm_lane_fmt
    import dm_arb_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_len,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_dout,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_mem_dout[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_mem_dout[31:16] : i_mem_dout[15:0];

    always_comb begin
        o_load   = i_mem_dout;
        o_merged = i_wdata;
        case (i_len)
            LEN_BYTE: begin
                o_load   = {{24{i_sign & w_byte[7]}}, w_byte};
                o_merged = i_mem_dout;
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            LEN_HALF: begin
                o_load   = {{16{i_sign & w_half[15]}}, w_half};
                o_merged = i_mem_dout;
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            default: begin
                o_load   = i_mem_dout;
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
// Two-port round-robin arbiter and access sequencer for a single-ported,
// synchronous-read data memory. Sub-word stores are read-modify-write,
// sub-word loads are lane-extracted and extended.
//   clk, reset            : clock, synchronous active-high reset
//   req/we/addr/wdata/len/sign 0,1 : requester inputs
//   gnt0/gnt1             : combinational accept
//   done0/done1, err      : registered completion pulse and its error flag
//   rdata                 : registered load result
//   mem_addr/mem_we/mem_din/mem_dout : memory interface
// Optional feature macro: DM_ARB_ALIGN_CHECK_EN (misaligned / reserved-length
// accesses complete with err=1 and never touch memory).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | arbitrate, latch the winning request
// S_READ  | memory address presented, read in flight
// S_WAIT  | read data valid: finish load, build RMW word, or report err
// S_WRITE | memory write issued, done pulses next cycle
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [31:0]       wdata0,
    input  logic [1:0]        len0,
    input  logic              sign0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata1,
    input  logic [1:0]        len1,
    input  logic              sign1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    arb_state_t        r_state;
    logic              r_ptr;
    logic              r_port;
    logic              r_we;
    logic [1:0]        r_addr_lo;
    logic [1:0]        r_len;
    logic              r_sign;
    logic [31:0]       r_wdata;
    logic              r_fault;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [31:0]       r_wbuf;
    logic [31:0]       r_rdata;
    logic              r_done0;
    logic              r_done1;
    logic              r_err;

    logic              w_any;
    logic              w_sel;
    logic              w_idle;
    logic              w_we;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [1:0]        w_len;
    logic              w_sign;
    logic              w_misalign;
    logic              w_word_st;
    logic [31:0]       w_merged;
    logic [31:0]       w_load;
    logic              w_unused_addr;

    // Both requesting: the port not granted last wins. Otherwise the lone
    // requester wins regardless of the pointer.
    assign w_any  = req0 | req1;
    assign w_sel  = (req0 & req1) ? ~r_ptr : req1;
    assign w_idle = (r_state == S_IDLE) & ~reset;

    assign gnt0 = w_idle & w_any & ~w_sel;
    assign gnt1 = w_idle & w_any &  w_sel;

    assign w_we    = w_sel ? we1    : we0;
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;
    assign w_len   = w_sel ? len1   : len0;
    assign w_sign  = w_sel ? sign1  : sign0;

    assign w_unused_addr = ^w_addr[31:ADDR_W];

`ifdef DM_ARB_ALIGN_CHECK_EN
    assign w_misalign = ((w_len == LEN_HALF) & w_addr[0])
                      | ((w_len == LEN_WORD) & (w_addr[1:0] != 2'b00))
                      |  (w_len == LEN_RSVD);
`else
    assign w_misalign = 1'b0;
`endif

    // Full-word stores (reserved length counts as word when unchecked) skip
    // the read and go straight to WRITE.
    assign w_word_st = w_we & ~w_misalign &
                       ((w_len == LEN_WORD) | (w_len == LEN_RSVD));

    dm_lane_fmt u_lane_fmt (
        .i_addr_lo  (r_addr_lo),
        .i_len      (r_len),
        .i_sign     (r_sign),
        .i_wdata    (r_wdata),
        .i_mem_dout (mem_dout),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_len      <= LEN_BYTE;
            r_sign     <= 1'b0;
            r_wdata    <= 32'h0;
            r_fault    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_wbuf     <= 32'h0;
            r_rdata    <= 32'h0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err    <= 1'b0;
            r_mem_we <= 1'b0;
            r_wbuf   <= 32'h0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ptr      <= w_sel;
                        r_port     <= w_sel;
                        r_we       <= w_we;
                        r_addr_lo  <= w_addr[1:0];
                        r_len      <= w_len;
                        r_sign     <= w_sign;
                        r_wdata    <= w_wdata;
                        r_fault    <= w_misalign;
                        r_mem_addr <= {w_addr[ADDR_W-1:2], 2'b00};
                        if (w_misalign) begin
                            r_state <= S_WAIT;
                        end else if (w_word_st) begin
                            // r_wbuf doubles as the registered mem_din
                            r_mem_we <= 1'b1;
                            r_wbuf   <= w_wdata;
                            r_state  <= S_WRITE;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: begin
                    if (r_fault) begin
                        r_done0 <= ~r_port;
                        r_done1 <=  r_port;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                        r_state <= S_IDLE;
                    end else if (!r_we) begin
                        r_done0 <= ~r_port;
                        r_done1 <=  r_port;
                        r_rdata <= w_load;
                        r_state <= S_IDLE;
                    end else begin
                        r_mem_we <= 1'b1;
                        r_wbuf   <= w_merged;
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_done0 <= ~r_port;
                    r_done1 <=  r_port;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done0    = r_done0;
    assign done1    = r_done1;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign mem_addr = r_mem_addr;
    assign mem_we   = r_mem_we;
    assign mem_din  = r_wbuf;

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 0, we0 = 0, sign0 = 0, req1 = 0, we1 = 0, sign1 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic [1:0]  len0 = 0, len1 = 0;
    logic        gnt0, gnt1, done0, done1, err, mem_we;
    logic [31:0] rdata, mem_din, mem_dout;
    logic [13:0] mem_addr;

    logic [31:0] mem [0:4095];
    logic [31:0] ref_mem [0:15];
    logic        bk_we = 1'b0;
    logic [11:0] bk_idx = 12'h0;
    logic [31:0] bk_data = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dm_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .len0(len0), .sign0(sign0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .len1(len1), .sign1(sign1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // synchronous-read single-port memory plus a bench backdoor write port
    always @(posedge clk) begin
        if (bk_we) mem[bk_idx] <= bk_data;
        else if (mem_we) mem[mem_addr[13:2]] <= mem_din;
        mem_dout <= mem[mem_addr[13:2]];
    end

    task automatic poke(input int idx, input logic [31:0] d);
        bk_idx = idx[11:0]; bk_data = d; bk_we = 1'b1;
        @(posedge clk); #1 bk_we = 1'b0;
    endtask

    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] ln, input logic sg);
        if (p == 0) begin req0 = v; we0 = we; addr0 = a; wdata0 = wd; len0 = ln; sign0 = sg; end
        else        begin req1 = v; we1 = we; addr1 = a; wdata1 = wd; len1 = ln; sign1 = sg; end
    endtask

    // One access on port p. lat/wr_lat are cycles after the grant cycle at
    // which done / mem_we were seen (-1 never, -2 no grant).
    task automatic do_access(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [1:0] ln, input logic sg, output int lat, output int wr_lat,
                             output logic [31:0] wr_din, output logic [31:0] wr_addr,
                             output logic [31:0] rd, output logic er);
        int n;
        logic g;
        lat = -2; wr_lat = -1; wr_din = 0; wr_addr = 0; rd = 0; er = 0;
        @(negedge clk);
        drive(p, 1'b1, we, a, wd, ln, sg);
        #1;
        n = 0;
        g = (p == 0) ? gnt0 : gnt1;
        while (!g && n < 40) begin
            @(negedge clk); #1; n++;
            g = (p == 0) ? gnt0 : gnt1;
        end
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        if (g) begin
            lat = -1;
            for (int k = 1; k <= 8; k++) begin
                if (mem_we) begin wr_lat = k; wr_din = mem_din; wr_addr = {18'h0, mem_addr}; end
                if ((p == 0 && done0) || (p == 1 && done1)) begin
                    lat = k; rd = rdata; er = err;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 1'b0);
        @(negedge clk); @(negedge clk); #1;
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
        total++; if (gnt1 !== 1'b0) begin bad++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
        total++; if ({done0, done1, err} !== 3'b000) begin bad++; $display("FAIL reset_done_err got=%b exp=000", {done0, done1, err}); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (mem_we !== 1'b0 || mem_din !== 32'h0) begin bad++; $display("FAIL reset_mem_wr got=%b/%h exp=0/0", mem_we, mem_din); end
        total++; if (mem_addr !== 14'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_word_store;
        int lat, wl; logic [31:0] wd, wa, rd; logic er;
        do_access(0, 1'b1, 32'h10, 32'h11223344, 2'b11, 1'b0, lat, wl, wd, wa, rd, er);
        total++; if (wl !== 1) begin bad++; $display("FAIL wst_we_lat got=%0d exp=1", wl); end
        total++; if (wd !== 32'h11223344) begin bad++; $display("FAIL wst_din got=%h exp=11223344", wd); end
        total++; if (wa !== 32'h10) begin bad++; $display("FAIL wst_addr got=%h exp=10", wa); end
        total++; if (lat !== 2) begin bad++; $display("FAIL wst_done_lat got=%0d exp=2", lat); end
        @(negedge clk);
        total++; if (done0 !== 1'b0) begin bad++; $display("FAIL wst_done_pulse got=%b exp=0", done0); end
        total++; if (mem[4] !== 32'h11223344) begin bad++; $display("FAIL wst_mem got=%h exp=11223344", mem[4]); end
    endtask

    task automatic test_byte_rmw;
        int lat, wl; logic [31:0] wd, wa, rd; logic er;
        poke(4, 32'hAABBCCDD);
        do_access(1, 1'b1, 32'h12, 32'h0000005A, 2'b00, 1'b0, lat, wl, wd, wa, rd, er);
        total++; if (wl !== 3) begin bad++; $display("FAIL rmw_we_lat got=%0d exp=3", wl); end
        total++; if (wd !== 32'hAA5ACCDD) begin bad++; $display("FAIL rmw_din got=%h exp=AA5ACCDD", wd); end
        total++; if (lat !== 4) begin bad++; $display("FAIL rmw_done_lat got=%0d exp=4", lat); end
        @(negedge clk);
        total++; if (mem[4] !== 32'hAA5ACCDD) begin bad++; $display("FAIL rmw_mem got=%h exp=AA5ACCDD", mem[4]); end
    endtask

    task automatic test_subword_loads;
        int lat, wl; logic [31:0] wd, wa, rd; logic er;
        poke(0, 32'h8000FF80);
        do_access(0, 1'b0, 32'h2, 32'h0, 2'b01, 1'b1, lat, wl, wd, wa, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL ldh_lat got=%0d exp=3", lat); end
        total++; if (rd !== 32'hFFFF8000) begin bad++; $display("FAIL ldh_rdata got=%h exp=FFFF8000", rd); end
        do_access(1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, lat, wl, wd, wa, rd, er);
        total++; if (lat !== 3) begin bad++; $display("FAIL ldb_lat got=%0d exp=3", lat); end
        total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL ldb_rdata got=%h exp=00000080", rd); end
        total++; if (wl !== -1) begin bad++; $display("FAIL ld_no_write got=%0d exp=-1", wl); end
    endtask

    task automatic test_arbitration;
        int seq[$];
        int both = 0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 2'b11, 1'b0);
        for (int i = 0; i < 24; i++) begin
            #1;
            if (gnt0 && gnt1) both++;
            else if (gnt0) seq.push_back(0);
            else if (gnt1) seq.push_back(1);
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        total++; if (both !== 0) begin bad++; $display("FAIL arb_double_gnt got=%0d exp=0", both); end
        total++; if (seq.size() !== 8) begin bad++; $display("FAIL arb_count got=%0d exp=8", seq.size()); end
        foreach (seq[i]) begin
            total++; if (seq[i] !== (i % 2)) begin bad++; $display("FAIL arb_order[%0d] got=%0d exp=%0d", i, seq[i], i % 2); end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_port1_alone;
        int n1 = 0, n0 = 0;
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0, 2'b11, 1'b0);
        for (int i = 0; i < 12; i++) begin
            #1;
            if (gnt1) n1++;
            if (gnt0) n0++;
            @(negedge clk);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        total++; if (n1 !== 4) begin bad++; $display("FAIL p1_alone_grants got=%0d exp=4", n1); end
        total++; if (n0 !== 0) begin bad++; $display("FAIL p1_alone_gnt0 got=%0d exp=0", n0); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n, seen_we = 0, seen_done = 0, lat, wl;
        logic [31:0] wd, wa, rd; logic er;
        poke(5, 32'h01020304);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 32'h15, 32'h000000EE, 2'b00, 1'b0);
        #1; n = 0;
        while (!gnt1 && n < 20) begin @(negedge clk); #1; n++; end
        total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL rmid_grant got=%b exp=1", gnt1); end
        @(negedge clk);                    // READ
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);                    // WAIT
        reset = 1'b1;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h14, 32'hDEADBEEF, 2'b11, 1'b0);
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rmid_we_after_reset got=%b exp=0", mem_we); end
        total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL rmid_gnt_in_reset got=%b exp=0", gnt0); end
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (mem_we) seen_we++;
            if (done0 || done1) seen_done++;
            @(negedge clk);
        end
        total++; if (seen_we !== 0) begin bad++; $display("FAIL rmid_late_write got=%0d exp=0", seen_we); end
        total++; if (seen_done !== 0) begin bad++; $display("FAIL rmid_late_done got=%0d exp=0", seen_done); end
        total++; if (mem[5] !== 32'h01020304) begin bad++; $display("FAIL rmid_mem got=%h exp=01020304", mem[5]); end
        do_access(0, 1'b0, 32'h14, 32'h0, 2'b11, 1'b0, lat, wl, wd, wa, rd, er);
        total++; if (lat !== 3 || rd !== 32'h01020304) begin bad++; $display("FAIL rmid_recover got=%0d/%h exp=3/01020304", lat, rd); end
    endtask

    task automatic test_misaligned;
        int lat, wl; logic [31:0] wd, wa, rd; logic er;
        poke(0, 32'h8000FF80);
        do_access(0, 1'b0, 32'h1, 32'h0, 2'b01, 1'b0, lat, wl, wd, wa, rd, er);
`ifdef DM_ARB_ALIGN_CHECK_EN
        total++; if (lat !== 2) begin bad++; $display("FAIL mis_lat got=%0d exp=2", lat); end
        total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_err got=%b exp=1", er); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL mis_rdata got=%h exp=0", rd); end
`else
        total++; if (lat !== 3) begin bad++; $display("FAIL mis_lat got=%0d exp=3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_err got=%b exp=0", er); end
        total++; if (rd !== 32'h0000FF80) begin bad++; $display("FAIL mis_rdata got=%h exp=0000FF80", rd); end
`endif
        total++; if (wl !== -1) begin bad++; $display("FAIL mis_no_write got=%0d exp=-1", wl); end
    endtask

    task automatic test_random;
        int lat, wl, idx, off, sh, p, exp_lat;
        logic [31:0] wd, wa, rd, d, word, v, mask, nw;
        logic er, we, sg;
        logic [1:0] ln;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            poke(i, d);
            ref_mem[i] = d;
        end
        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 15);
            case ($urandom_range(0, 2))
                0:       begin ln = 2'b00; off = $urandom_range(0, 3); end
                1:       begin ln = 2'b01; off = 2 * $urandom_range(0, 1); end
                default: begin ln = 2'b11; off = 0; end
            endcase
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            p  = $urandom_range(0, 1);
            d  = $urandom;
            sh = off * 8;
            word = ref_mem[idx];
            mask = (ln == 2'b00) ? (32'hFF << sh) : (ln == 2'b01) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
            do_access(p, we, 32'(idx * 4 + off), d, ln, sg, lat, wl, wd, wa, rd, er);
            if (!we) begin
                v = (word & mask) >> sh;
                if (sg && ln == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
                if (sg && ln == 2'b01 && v[15]) v = v | 32'hFFFF0000;
                total++; if (lat !== 3) begin bad++; $display("FAIL rnd%0d_ld_lat got=%0d exp=3", t, lat); end
                total++; if (rd !== v) begin bad++; $display("FAIL rnd%0d_ld_data got=%h exp=%h", t, rd, v); end
            end else begin
                nw = (word & ~mask) | ((d << sh) & mask);
                ref_mem[idx] = nw;
                exp_lat = (ln == 2'b11) ? 2 : 4;
                total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd%0d_st_lat got=%0d exp=%0d", t, lat, exp_lat); end
                total++; if (wd !== nw || wa !== 32'(idx * 4)) begin bad++; $display("FAIL rnd%0d_st_wr got=%h@%h exp=%h@%h", t, wd, wa, nw, idx * 4); end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            total++; if (mem[i] !== ref_mem[i]) begin bad++; $display("FAIL rnd_mem[%0d] got=%h exp=%h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_word_store;
        test_byte_rmw;
        test_subword_loads;
        test_arbitration;
        test_port1_alone;
        test_reset_mid;
        test_misaligned;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Sequencer and two-port arbiter in front of the single-ported, synchronous-read data memory. It shares the memory between requester 0 (CPU MEM stage) and requester 1 (debug/DMA port), and turns every access into a fixed sequence of memory cycles. Sub-word stores become a read-modify-write. Sub-word loads are lane-extracted and extended before return.

## Interface
Parameters:
- `ADDR_W`, default 14: memory byte-address width; `mem_addr` is word-aligned.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req0`/`req1` in 1: request valid.
- `we0`/`we1` in 1: 1 = store, 0 = load.
- `addr0`/`addr1` in 32: byte address.
- `wdata0`/`wdata1` in 32: store data, right-aligned.
- `len0`/`len1` in 2: access length. 00 = byte, 01 = half, 11 = word, 10 = reserved.
- `sign0`/`sign1` in 1: sign-extend a sub-word load.
- `gnt0`/`gnt1` out 1: combinational; request accepted this cycle.
- `done0`/`done1` out 1: registered; one-cycle completion pulse.
- `rdata` out 32: registered load result; valid when either `done` is high and the access was a load.
- `err` out 1: registered; qualifies `done` (see Configuration).
- `mem_addr` out ADDR_W: `{addr[ADDR_W-1:2], 2'b00}` of the latched request.
- `mem_we` out 1: memory write enable.
- `mem_din` out 32: memory write data.
- `mem_dout` in 32: read data, valid the cycle after the address is presented.

## Operation
- **FSM states:** IDLE, READ, WAIT, WRITE.
- **IDLE:**
  - Any `req` high means arbitrate, assert exactly one `gnt`, and latch we/addr/wdata/len/sign and the port id.
  - Next state: word store goes to WRITE; anything else goes to READ.
- **Arbitration:**
  - Round-robin on a last-granted pointer; the pointer resets to 1, so port 0 wins first.
  - Both requesting: the port not granted last wins.
  - One requesting: that port wins regardless of the pointer.
- **Request holding:**
  - A requester holds `req` until `gnt`.
  - `req` still high on the next IDLE visit is a new request.
- **READ:** drive `mem_addr`, `mem_we`=0. Next state: WAIT.
- **WAIT, load:**
  - Lane-extract from `mem_dout` and register the result into `rdata`.
  - Pulse `done` of the latched port; go to IDLE.
- **WAIT, sub-word store:** register the merged word (store lanes replaced, other lanes kept from `mem_dout`) into the write buffer; go to WRITE.
- **WRITE:**
  - Drive `mem_we`=1 and `mem_din`: `wdata` for a word store, the write buffer otherwise.
  - Pulse `done` next cycle; go to IDLE.
- **Lanes (little-endian):**
  - Byte k occupies bits [8k+7:8k], with k = addr[1:0].
  - Half at addr[1]=0 is [15:0]; at addr[1]=1 it is [31:16].
  - Load extension: upper bits are `sign & msb` of the extracted lane, otherwise zero.
- **Outputs outside WRITE:** `mem_we`=0, `mem_din`=0. `mem_addr` holds its last value.
- **len=10:** handled as word when the check is compiled out.

## Timing
- **Grant cycle T:** the edge at the end of cycle T latches the request.
- **Latency:**
  - Word store: `mem_we` at T+1, `done` at T+2.
  - Load: READ T+1, WAIT T+2, `done` + `rdata` at T+3.
  - Sub-word store: READ T+1, WAIT T+2, WRITE T+3, `done` T+4.
- **Back-to-back:** a new grant can occur in the cycle `done` is high (FSM is in IDLE).
- **Reset values:** state IDLE, pointer=1, `gnt*`=0, `done*`=0, `err`=0, `rdata`=0, `mem_we`=0, `mem_din`=0, `mem_addr`=0.
- **Reset mid-operation:** the access is abandoned. No write is issued after the reset edge and no `done` follows.
- **Reset asserted in IDLE:** `gnt` is forced to 0 that cycle.

## Configuration
- **`DM_ARB_ALIGN_CHECK_EN` defined:**
  - Half with addr[0]=1, word with addr[1:0]≠0, or len=10 is still granted, but goes IDLE → WAIT with no memory access and no write.
  - At T+2: `done` of the port with `err`=1 and `rdata`=0.
- **`DM_ARB_ALIGN_CHECK_EN` undefined:**
  - Offending low address bits are ignored: half uses addr[1], word uses addr[1:0]=00.
  - `err` is tied to 0.

## Structure
- **Package `dm_arb_pkg`:**
  - Length constants LEN_BYTE=2'b00, LEN_HALF=2'b01, LEN_WORD=2'b11.
  - FSM state encoding.
- **Sub-module `dm_lane_fmt`:** combinational lane merge (store) and lane extract/extend (load), driven by latched addr[1:0], len, sign.
- **Top-level contents:** FSM, arbiter pointer, request latches, write buffer, `rdata`, and the done/err registers.

## Test plan
- **Word store:** port 0 stores 0x11223344 to 0x10.
  - `gnt0` at T, `mem_we`=1 at T+1 with `mem_din`=0x11223344 and `mem_addr`=0x10, `done0` at T+2.
- **Byte store (RMW):** memory[0x10]=0xAABBCCDD; port 1 stores byte 0x5A to 0x12.
  - Read at T+1, write at T+3 of 0xAA5ACCDD, `done1` at T+4.
- **Sub-word loads on 0x8000FF80:**
  - Signed half at 0x2: `rdata`=0xFFFF8000 at T+3.
  - Unsigned byte at 0x0: `rdata`=0x00000080.
- **Arbitration:**
  - Both ports request continuously: grants alternate 0,1,0,1, starting with 0 after reset.
  - Port 1 alone: granted every IDLE.
- **Reset mid-operation:** reset asserted during WAIT of a byte store. No `mem_we` afterwards, no `done`, FSM in IDLE, memory unchanged.
- **Misaligned half load at 0x1:**
  - With `DM_ARB_ALIGN_CHECK_EN`: `done0`+`err` at T+2, no memory read.
  - Without it: the access behaves as a half load at 0x0.
